// File: rtl/onchip_mem_stream_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_writer_if
// Description : Bundles the 8-bit valid/ready byte stream and the Avalon-style
//               RAM write port used by onchip_mem_stream_writer.
//               slave  : the writer block (sinks the stream, drives the RAM).
//               master : the environment (sources the stream, observes RAM).
//               Stream : in_data[7:0], in_valid, in_last, in_ready
//               RAM    : mem_address, mem_byteenable, mem_chipselect,
//                        mem_write, mem_writedata, mem_clken
// Revision    : 1.0 - initial release
// ============================================================================
interface onchip_mem_stream_writer_if #(
    parameter int ADDR_W = 14
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready,
        output mem_address, mem_byteenable, mem_chipselect,
        output mem_write, mem_writedata, mem_clken
    );

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready,
        input  mem_address, mem_byteenable, mem_chipselect,
        input  mem_write, mem_writedata, mem_clken
    );
endinterface
`default_nettype wire

// File: rtl/onchip_mem_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : onchip_mem_stream_writer
// Description : Packs an 8-bit byte stream little-endian into 32-bit words and
//               writes them, one cycle per word, into a DEPTH x 32 on-chip RAM
//               starting at base_addr. Stops on num_bytes, in_last, or the end
//               of the RAM (flagged as overflow, no wrap).
// Ports       : clk, reset (sync, active-high)
//               start, base_addr, num_bytes  - transfer request (IDLE only)
//               bus (slave modport)          - byte stream in, RAM port out
//               busy, done, overflow         - status
//               words_written                - words of current/last transfer
// Build macro : STREAM_WR_ZERO_PAD_EN - when defined, the final partial word
//               is written with all four byte lanes enabled (unused lanes 0).
// Revision    : 1.0 - initial release
// ============================================================================
module onchip_mem_stream_writer #(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 10240,
    parameter int LEN_W  = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [LEN_W-1:0]  num_bytes,
    onchip_mem_stream_writer_if.slave bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [ADDR_W:0]        words_written
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0]   c_depth     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic [1:0]        r_lane;
    logic [31:0]       r_data;
    logic [3:0]        r_be;
    logic              r_fin;       // the word in flight is the last of the transfer
    logic              r_overflow;
    logic [ADDR_W:0]   r_words;

    logic              w_bad_base;
    logic              w_xfer;
    logic              w_count_hit;
    logic              w_word_end;
    logic [3:0]        w_be_wr;

    assign w_bad_base  = {1'b0, base_addr} >= c_depth;
    assign w_xfer      = (r_state == S_FILL) && bus.in_valid;
    assign w_count_hit = (r_count + LEN_W'(1)) == r_len;
    assign w_word_end  = (r_lane == 2'd3) || w_count_hit || bus.in_last;

`ifdef STREAM_WR_ZERO_PAD_EN
    // Unused lanes already hold 0, so enabling them all pads the tail word.
    assign w_be_wr = 4'hF;
`else
    assign w_be_wr = r_be;
`endif

    // ------------------------------------------------------------------ state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad_base || (num_bytes == '0)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (w_xfer && w_word_end) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_fin || (r_addr == c_last_addr)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_FILL;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        bus.in_ready       = 1'b0;
        bus.mem_chipselect = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_byteenable = 4'h0;
        busy               = 1'b0;
        done               = 1'b0;
        case (r_state)
            S_FILL: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            S_WRITE: begin
                bus.mem_chipselect = 1'b1;
                bus.mem_write      = 1'b1;
                bus.mem_byteenable = w_be_wr;
                busy               = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_address   = r_addr;
    assign bus.mem_writedata = r_data;
    assign bus.mem_clken     = 1'b1;
    assign overflow          = r_overflow;
    assign words_written     = r_words;

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_lane     <= 2'd0;
            r_data     <= 32'h0;
            r_be       <= 4'h0;
            r_fin      <= 1'b0;
            r_overflow <= 1'b0;
            r_words    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr     <= base_addr;
                        r_len      <= num_bytes;
                        r_count    <= '0;
                        r_lane     <= 2'd0;
                        r_data     <= 32'h0;
                        r_be       <= 4'h0;
                        r_fin      <= 1'b0;
                        r_overflow <= w_bad_base;
                        r_words    <= '0;
                    end
                end
                S_FILL: begin
                    if (w_xfer) begin
                        r_data[8*r_lane +: 8] <= bus.in_data;
                        r_be[r_lane]          <= 1'b1;
                        r_lane                <= r_lane + 2'd1;
                        r_count               <= r_count + LEN_W'(1);
                        if (w_count_hit || bus.in_last) begin
                            r_fin <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_words <= r_words + (ADDR_W+1)'(1);
                    r_lane  <= 2'd0;
                    r_data  <= 32'h0;
                    r_be    <= 4'h0;
                    if (!r_fin) begin
                        if (r_addr == c_last_addr) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_onchip_mem_stream_writer
// Description : Self-checking bench for onchip_mem_stream_writer. Expected RAM
//               writes are queued per scenario and popped by a write monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_stream_writer;

    localparam int ADDR_W = 14;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 10240;

`ifdef STREAM_WR_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_bytes;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   words_written;

    always #5 clk = ~clk;

    onchip_mem_stream_writer_if #(.ADDR_W(ADDR_W)) bus ();

    onchip_mem_stream_writer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .LEN_W  (LEN_W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_bytes     (num_bytes),
        .bus           (bus.slave),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .words_written (words_written)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] byte_q[$];
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;
    wr_t        mon_got;
    wr_t        mon_exp;

    // Write monitor: every RAM write must match the next expected entry.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (bus.mem_write === 1'b1) begin
            mon_got = '{bus.mem_address, bus.mem_byteenable, bus.mem_writedata};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%h be=%h data=%h, required no write",
                         mon_got.addr, mon_got.be, mon_got.data);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL write: got addr=%h be=%h data=%h, required addr=%h be=%h data=%h",
                             mon_got.addr, mon_got.be, mon_got.data,
                             mon_exp.addr, mon_exp.be, mon_exp.data);
                end
            end
            total++;
            if ({bus.in_ready, bus.mem_chipselect} !== 2'b01) begin
                bad++;
                $display("FAIL write_strobes: got in_ready=%b cs=%b, required in_ready=0 cs=1",
                         bus.in_ready, bus.mem_chipselect);
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        num_bytes = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Presents byte_q until n bytes are accepted or the budget runs out.
    // start_at > 0 pulses a (to-be-ignored) start in that cycle.
    task automatic drive_stream(input int n, input int last_idx, input bit gaps,
                                input int start_at, input int budget, output int accepted);
        int cyc;
        cyc = 0;
        accepted = 0;
        while (accepted < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = (cyc == start_at);
            if (cyc == start_at) begin
                base_addr = 14'h0100;
                num_bytes = 16'd4;
            end
            if (gaps && (cyc % 2 == 0)) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = byte_q[accepted];
                bus.in_last  = (accepted == last_idx);
            end
            if (bus.in_valid && bus.in_ready) accepted++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        start        = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout: got busy=%b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({bus.in_ready, bus.mem_address, bus.mem_byteenable, bus.mem_chipselect,
             bus.mem_write, bus.mem_writedata, busy, done, overflow, words_written,
             bus.mem_clken} !== {(2 + ADDR_W + 4 + 32 + 3 + ADDR_W + 1 + 2)'(1)}) begin
            bad++;
            $display("FAIL reset_outputs: got ready=%b addr=%h be=%h cs=%b wr=%b data=%h busy=%b done=%b ovf=%b words=%0d clken=%b, required all 0 and clken=1",
                     bus.in_ready, bus.mem_address, bus.mem_byteenable, bus.mem_chipselect,
                     bus.mem_write, bus.mem_writedata, busy, done, overflow, words_written,
                     bus.mem_clken);
        end
    endtask

    task automatic test_full_words();
        int acc;
        done_cnt = 0;
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        sb.push_back('{14'h0010, 4'hF, 32'h04030201});
        sb.push_back('{14'h0011, 4'hF, 32'h08070605});
        do_start(14'h0010, 16'd8);
        drive_stream(8, -1, 1'b0, 0, 40, acc);
        wait_idle("full");
        total++;
        if (words_written !== 15'd2 || overflow !== 1'b0 || done_cnt != 1) begin
            bad++;
            $display("FAIL full_status: got words=%0d ovf=%b done_cnt=%0d, required 2 0 1",
                     words_written, overflow, done_cnt);
        end
        total++;
        if (bus.mem_address !== 14'h0011 || sb.size() != 0) begin
            bad++;
            $display("FAIL full_hold: got addr=%h pending=%0d, required 0011 0",
                     bus.mem_address, sb.size());
        end
    endtask

    task automatic test_partial();
        int acc;
        done_cnt = 0;
        byte_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        sb.push_back('{14'h0020, 4'hF, 32'hA3A2A1A0});
        sb.push_back('{14'h0021, ZP ? 4'hF : 4'h3, 32'h0000A5A4});
        do_start(14'h0020, 16'd6);
        drive_stream(6, -1, 1'b0, 0, 40, acc);
        wait_idle("partial");
        total++;
        if (words_written !== 15'd2 || done_cnt != 1 || sb.size() != 0) begin
            bad++;
            $display("FAIL partial_status: got words=%0d done_cnt=%0d pending=%0d, required 2 1 0",
                     words_written, done_cnt, sb.size());
        end
    endtask

    task automatic test_last();
        int acc;
        done_cnt = 0;
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        sb.push_back('{14'h0000, ZP ? 4'hF : 4'h7, 32'h00332211});
        do_start(14'h0000, 16'd100);
        drive_stream(3, 2, 1'b0, 0, 40, acc);
        wait_idle("last");
        total++;
        if (words_written !== 15'd1 || done_cnt != 1 || overflow !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL last_status: got words=%0d done_cnt=%0d ovf=%b pending=%0d, required 1 1 0 0",
                     words_written, done_cnt, overflow, sb.size());
        end
    endtask

    task automatic test_overflow();
        int acc;
        done_cnt = 0;
        byte_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
        sb.push_back('{14'(DEPTH - 1), 4'hF, 32'h53525150});
        do_start(14'(DEPTH - 1), 16'd8);
        drive_stream(8, -1, 1'b0, 0, 20, acc);
        wait_idle("ovf_end");
        total++;
        if (acc != 4 || overflow !== 1'b1 || words_written !== 15'd1 || done_cnt != 1 || sb.size() != 0) begin
            bad++;
            $display("FAIL ovf_end: got accepted=%0d ovf=%b words=%0d done_cnt=%0d pending=%0d, required 4 1 1 1 0",
                     acc, overflow, words_written, done_cnt, sb.size());
        end
        done_cnt = 0;
        do_start(14'(DEPTH), 16'd8);
        wait_idle("ovf_base");
        @(negedge clk);
        total++;
        if (overflow !== 1'b1 || words_written !== 15'd0 || done_cnt != 1) begin
            bad++;
            $display("FAIL ovf_base: got ovf=%b words=%0d done_cnt=%0d, required 1 0 1",
                     overflow, words_written, done_cnt);
        end
    endtask

    task automatic test_gaps_and_start();
        int acc;
        done_cnt = 0;
        byte_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        sb.push_back('{14'h0010, 4'hF, 32'h04030201});
        sb.push_back('{14'h0011, 4'hF, 32'h08070605});
        do_start(14'h0010, 16'd8);
        drive_stream(8, -1, 1'b1, 5, 60, acc);
        wait_idle("gaps");
        @(negedge clk);
        total++;
        if (words_written !== 15'd2 || done_cnt != 1 || overflow !== 1'b0 || sb.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL gaps_status: got words=%0d done_cnt=%0d ovf=%b pending=%0d busy=%b, required 2 1 0 0 0",
                     words_written, done_cnt, overflow, sb.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        done_cnt = 0;
        byte_q = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
        do_start(14'h0040, 16'd4);
        drive_stream(2, -1, 1'b0, 0, 20, acc);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.in_ready, bus.mem_address, bus.mem_byteenable, bus.mem_write,
             bus.mem_writedata, busy, done, overflow, words_written} !== '0) begin
            bad++;
            $display("FAIL reset_mid: got ready=%b addr=%h be=%h wr=%b data=%h busy=%b done=%b ovf=%b words=%0d, required all 0",
                     bus.in_ready, bus.mem_address, bus.mem_byteenable, bus.mem_write,
                     bus.mem_writedata, busy, done, overflow, words_written);
        end
        reset = 1'b0;
        byte_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
        sb.push_back('{14'h0005, 4'hF, 32'hC3C2C1C0});
        do_start(14'h0005, 16'd4);
        drive_stream(4, -1, 1'b0, 0, 20, acc);
        wait_idle("after_reset");
        total++;
        if (words_written !== 15'd1 || done_cnt != 1 || sb.size() != 0) begin
            bad++;
            $display("FAIL after_reset: got words=%0d done_cnt=%0d pending=%0d, required 1 1 0",
                     words_written, done_cnt, sb.size());
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        base_addr    = '0;
        num_bytes    = '0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_full_words();
        test_partial();
        test_last();
        test_overflow();
        test_gaps_and_start();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/onchip_mem_stream_writer.md
Name: onchip_mem_stream_writer

Overview:
- Upstream feeder for the 10240 x 32-bit single-port on-chip RAM.
- Accepts an 8-bit valid/ready byte stream, packs bytes little-endian into 32-bit words and issues single-cycle writes on the RAM's Avalon-style slave port (address, byteenable, chipselect, write, writedata, clken).
- Used to load captured frame/GPS byte streams into RAM for the processor without CPU copying.

Parameters:
- ADDR_W, 14, word address width, matches the RAM port.
- DEPTH, 10240, number of 32-bit words in the RAM; valid addresses are 0..DEPTH-1.
- LEN_W, 16, width of the byte-count input; must hold DEPTH*4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a transfer; ignored unless idle.
- base_addr  in  ADDR_W  first word address, sampled on an accepted start.
- num_bytes  in  LEN_W  bytes to transfer, sampled on an accepted start.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  qualifies the final byte of a stream; ends the transfer early.
- in_ready  out  1  block accepts a byte this cycle.
- mem_address  out  ADDR_W  RAM word address.
- mem_byteenable  out  4  RAM byte lanes.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  packed word.
- mem_clken  out  1  RAM clock enable; constant 1.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- overflow  out  1  sticky; transfer truncated at end of RAM or bad base_addr. Cleared by the next accepted start.
- words_written  out  ADDR_W+1  words written in the current or most recent transfer.

Behaviour:
- Reset values:
  - All outputs 0 except mem_clken=1.
  - State IDLE; the lane accumulator is cleared.
- Reset mid-transfer: the partial word is discarded, no write is issued and done does not pulse.
- Packing and handshake:
  - Byte k of a word goes to writedata[8k+7:8k]; the first accepted byte goes to lane 0.
  - A byte is transferred when in_valid & in_ready.
- State IDLE:
  - in_ready=0, busy=0.
  - On start: latch base_addr and num_bytes, clear overflow and words_written, then:
    - base_addr >= DEPTH -> set overflow, go to DONE.
    - num_bytes == 0 -> go to DONE.
    - Otherwise -> go to FILL with lane=0 and byte count=0.
- State FILL:
  - in_ready=1, busy=1.
  - On each transfer: store the byte in the current lane, set that lane's byteenable bit, increment lane and the byte count.
  - Go to WRITE in the same cycle as the transfer if any of these holds: lane was 3, the count reaches num_bytes, or in_last=1.
- State WRITE (exactly one cycle):
  - in_ready=0; mem_chipselect=mem_write=1; address, data and byteenable are presented from registers.
  - Unused lanes of a partial word carry data 0.
  - Next cycle: words_written increments and the lane accumulator is cleared.
  - If the transfer is finished -> DONE.
  - Else, if the address was DEPTH-1 -> set overflow, go to DONE (no wrap).
  - Else -> increment the address, go to FILL.
- State DONE:
  - done=1 for one cycle, busy=1.
  - Then IDLE; start is ignored during this cycle.
- mem_chipselect and mem_write are asserted only in WRITE; mem_address holds its last value otherwise.
- Throughput: a full word takes 4 FILL transfers plus 1 WRITE cycle. in_valid gaps stall FILL without limit.
- Simultaneous events:
  - in_last on the byte that also fills lane 3 or reaches num_bytes gives one write, then DONE.
  - start asserted while busy is ignored.
  - Bytes presented while in_ready=0 are not consumed.

Optional Feature:
- Macro STREAM_WR_ZERO_PAD_EN.
- Defined: the final partial word is written with mem_byteenable=4'b1111 and zeros in the unused lanes, so RAM contents past the stream end are deterministic.
- Undefined: the final partial word enables only the lanes that received bytes; unused RAM bytes keep their old contents.
- Full words are identical in both builds.

Test Plan:
- base=0x0010, num_bytes=8, bytes 0x01..0x08, in_valid always high -> writes 0x04030201 @0x0010 and 0x08070605 @0x0011, byteenable 4'hF, done pulses once, words_written=2, overflow=0.
- base=0x0020, num_bytes=6, bytes 0xA0..0xA5 -> writes 0xA3A2A1A0 @0x0020, then @0x0021:
  - undefined build: data 0x0000A5A4 with byteenable 4'b0011;
  - defined build: byteenable 4'hF.
- base=0x0000, num_bytes=100, in_last on the 3rd byte (0x11,0x22,0x33) -> single write 0x00332211, byteenable 4'b0111, done, words_written=1.
- base=10239, num_bytes=8 -> one write @10239, overflow=1, done, words_written=1, remaining bytes not accepted; base=10240 -> no write, overflow=1, done.
- in_valid toggling every other cycle plus a start pulse mid-transfer -> same RAM contents as the back-to-back case, start ignored, in_ready low during every WRITE cycle.
- reset asserted after 2 of 4 bytes -> no write issued, all outputs 0 the next cycle; a subsequent start with base=0x0005, num_bytes=4 -> single clean write @0x0005.
